// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types for the UART receive path.
// Holds the parity modes, FSM states and the stored FIFO word layout.
package uart_rx_pkg;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;
  localparam logic [1:0] PARITY_RSVD = 2'b11;

  typedef enum logic [1:0] {
    NONE = PARITY_NONE,
    EVEN = PARITY_EVEN,
    ODD  = PARITY_ODD,
    RSVD = PARITY_RSVD
  } parity_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } rx_state_e;

  typedef struct packed {
    logic       frame_err;
    logic       parity_err;
    logic [8:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_frame_fifo.sv
// uart_rx_frame_fifo: generic first-word-fall-through sync FIFO.
// Ports: push/wdata in, pop in, rdata (0 when empty), full, empty, count.
module uart_rx_frame_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop frees the slot the push needs when full.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampled UART receiver, runtime baud/parity/stop, FWFT output FIFO.
// Ports: rx_serial, baud_div, parity_mode, two_stop in; rx_* FIFO head, fifo_count, overrun out; break_det with UART_RX_BREAK_DET_EN.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int OS_RATE    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_serial,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          ovr_clr
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic                          break_det
`endif
);

  localparam int OSW = $clog2(OS_RATE);
  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [OSW-1:0] OS_MID = OSW'(OS_RATE / 2 - 1);
  localparam logic [OSW-1:0] OS_END = OSW'(OS_RATE - 1);
  localparam logic [BCW-1:0] BC_END = BCW'(DATA_BITS);

  rx_state_e            state;
  parity_mode_e         mode_l;
  logic                 rx_m;
  logic                 rx_s;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [DIV_WIDTH-1:0] div_max;
  logic                 tick;
  logic                 os_mid;
  logic                 os_end;
  logic [OSW-1:0]       os_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 two_l;
  logic                 par_en;
  logic                 par_bit;
  logic                 fe;
  logic                 pe;
  logic                 brk;
  logic                 brk_hold;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 unused_data;
  rx_entry_t            w_entry;
  rx_entry_t            r_entry;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_serial;
      rx_s <= rx_m;
    end
  end

  assign div_max = (baud_div == '0) ? '0 : baud_div - 1'b1;
  assign tick    = (div_cnt == div_max);
  assign os_mid  = tick && (os_cnt == OS_MID);
  assign os_end  = tick && (os_cnt == OS_END);
  assign par_en  = (mode_l == EVEN) || (mode_l == ODD);

  // Held at 0 in IDLE so every frame starts a fresh divider period.
  always_ff @(posedge clk) begin
    if (!rst_n || state == IDLE) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  logic brk_wait;
  assign brk      = (shreg == '0) && !(par_en && par_bit) && !rx_s;
  assign brk_hold = brk_wait;
`else
  assign brk      = 1'b0;
  assign brk_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode_l  <= NONE;
      two_l   <= 1'b0;
      os_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      fe      <= 1'b0;
      pe      <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      brk_wait  <= 1'b0;
      break_det <= 1'b0;
`endif
    end else begin
`ifdef UART_RX_BREAK_DET_EN
      break_det <= 1'b0;
      if (state == IDLE) begin
        brk_wait <= 1'b0;
      end
`endif
      if (state != IDLE && tick) begin
        os_cnt <= os_end ? '0 : os_cnt + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            mode_l  <= parity_mode_e'(parity_mode);
            two_l   <= two_stop;
            os_cnt  <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
            fe      <= 1'b0;
            pe      <= 1'b0;
          end
        end
        START: begin
          if (os_mid && rx_s) begin
            state <= IDLE;
          end else if (os_end) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (os_mid) begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (os_end && bit_cnt == BC_END) begin
            state <= par_en ? PARITY : STOP1;
          end
        end
        PARITY: begin
          if (os_mid) begin
            par_bit <= rx_s;
            pe <= (mode_l == EVEN && (^shreg ^ rx_s))
               || (mode_l == ODD && !(^shreg ^ rx_s));
          end
          if (os_end) begin
            state <= STOP1;
          end
        end
        STOP1: begin
          if (brk_hold) begin
            if (rx_s) begin
              state <= IDLE;
            end
          end else if (os_mid) begin
            fe <= !rx_s;
            if (brk) begin
`ifdef UART_RX_BREAK_DET_EN
              brk_wait  <= 1'b1;
              break_det <= 1'b1;
`endif
            end else if (!two_l) begin
              // Leave at mid-stop so the next start edge is not missed.
              state <= IDLE;
            end
          end else if (os_end && two_l) begin
            state <= STOP2;
          end
        end
        STOP2: begin
          if (os_mid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push = os_mid && ((state == STOP2)
             || (state == STOP1 && !two_l && !brk && !brk_hold));

  // The stop bit being sampled this cycle folds into the framing flag.
  always_comb begin
    w_entry = '0;
    w_entry.frame_err  = fe | !rx_s;
    w_entry.parity_err = pe;
    w_entry.data[DATA_BITS-1:0] = shreg;
  end

  uart_rx_frame_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (w_entry),
    .pop   (pop),
    .rdata (r_entry),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign rx_valid      = !empty;
  assign pop           = rx_valid && rx_ready;
  assign rx_data       = r_entry.data[DATA_BITS-1:0];
  assign rx_parity_err = r_entry.parity_err;
  assign rx_frame_err  = r_entry.frame_err;
  assign rx_busy       = (state != IDLE);
  assign unused_data   = ^r_entry.data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (push && full && !pop) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames with a scoreboard queue of expected FIFO words.
// A negedge monitor pops and compares whenever the DUT hands over an entry.
module tb_uart_rx_core;

  localparam int DB  = 8;
  localparam int FD  = 4;
  localparam int OSR = 16;
  localparam int DIV = 3;
  localparam int BIT = OSR * DIV;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  rx_serial;
  logic [15:0]           baud_div;
  logic [1:0]            parity_mode;
  logic                  two_stop;
  logic [DB-1:0]         rx_data;
  logic                  rx_parity_err;
  logic                  rx_frame_err;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  rx_busy;
  logic [$clog2(FD):0]   fifo_count;
  logic                  overrun;
  logic                  ovr_clr;
`ifdef UART_RX_BREAK_DET_EN
  logic                  break_det;
`endif

  int n_chk   = 0;
  int n_pass  = 0;
  int brk_cnt = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_core #(
    .DATA_BITS  (DB),
    .FIFO_DEPTH (FD),
    .DIV_WIDTH  (16),
    .OS_RATE    (OSR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_serial     (rx_serial),
    .baud_div      (baud_div),
    .parity_mode   (parity_mode),
    .two_stop      (two_stop),
    .rx_data       (rx_data),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_busy       (rx_busy),
    .fifo_count    (fifo_count),
    .overrun       (overrun),
    .ovr_clr       (ovr_clr)
`ifdef UART_RX_BREAK_DET_EN
    ,
    .break_det     (break_det)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL entry: got %0h, expected no entry",
                 {rx_frame_err, rx_parity_err, rx_data});
      end else begin
        chk("entry", 32'({rx_frame_err, rx_parity_err, rx_data}),
            32'(exp_q.pop_front()));
      end
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  always @(negedge clk) begin
    if (break_det) begin
      brk_cnt++;
    end
  end
`endif

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic drive(input logic b, input int n);
    rx_serial = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic pen, input logic pb);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) begin
      drive(d[i], BIT);
    end
    if (pen) begin
      drive(pb, BIT);
    end
    drive(1'b1, BIT);
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(rx_valid), 32'd0);
    rx_ready = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    rx_serial   = 1'b1;
    baud_div    = 16'(DIV);
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    rx_ready    = 1'b0;
    ovr_clr     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_head", 32'({rx_frame_err, rx_parity_err, rx_data}), 32'd0);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    drive(1'b1, BIT);

    exp_q.push_back({1'b0, 1'b0, 8'hA5});
    send(8'hA5, 1'b0, 1'b0);
    drive(1'b1, 2 * BIT);
    chk("t1_head", 32'({rx_frame_err, rx_parity_err, rx_data}), 32'h0A5);
    chk("t1_count", 32'(fifo_count), 32'd1);
    chk("t1_busy", 32'(rx_busy), 32'd0);
    drain();

    parity_mode = 2'b01;
    exp_q.push_back({1'b0, 1'b1, 8'h03});
    send(8'h03, 1'b1, 1'b1);
    drive(1'b1, BIT);
    parity_mode = 2'b10;
    exp_q.push_back({1'b0, 1'b0, 8'h03});
    send(8'h03, 1'b1, 1'b1);
    drive(1'b1, 2 * BIT);
    chk("t2_count", 32'(fifo_count), 32'd2);
    drain();

    parity_mode = 2'b00;
    two_stop = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 8'h5A});
    send(8'h5A, 1'b0, 1'b0);
    drive(1'b0, 36);
    drive(1'b1, 2 * BIT);
    chk("t3_head", 32'({rx_frame_err, rx_parity_err, rx_data}), 32'h25A);
    two_stop = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 8'h5A});
    exp_q.push_back({1'b0, 1'b0, 8'hFF});
    send(8'h5A, 1'b0, 1'b0);
    drive(1'b0, BIT);
    drive(1'b1, 11 * BIT);
    chk("t3_count", 32'(fifo_count), 32'd3);
    drain();

    drive(1'b0, 12);
    chk("glitch_busy", 32'(rx_busy), 32'd1);
    drive(1'b1, 24);
    chk("glitch_idle", 32'(rx_busy), 32'd0);
    drive(1'b1, BIT);
    chk("glitch_count", 32'(fifo_count), 32'd0);

    for (int i = 1; i <= 5; i++) begin
      logic [7:0] d;
      d = 8'(i * 8'h11);
      if (i <= 4) begin
        exp_q.push_back({2'b00, d});
      end
      send(d, 1'b0, 1'b0);
      drive(1'b1, BIT);
    end
    chk("ovr_count", 32'(fifo_count), 32'd4);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_head", 32'(rx_data), 32'h11);
    drain();
    chk("ovr_sticky", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    @(posedge clk);
    #1;
    ovr_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);

    drive(1'b0, BIT);
    drive(1'b0, BIT);
    drive(1'b1, BIT);
    drive(1'b1, BIT / 2);
    rx_serial = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_busy", 32'(rx_busy), 32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 2 * BIT);
    exp_q.push_back({2'b00, 8'h3C});
    send(8'h3C, 1'b0, 1'b0);
    drive(1'b1, 2 * BIT);
    chk("t6_count", 32'(fifo_count), 32'd1);
    drain();

`ifdef UART_RX_BREAK_DET_EN
    drive(1'b0, 15 * BIT);
    chk("brk_busy", 32'(rx_busy), 32'd1);
    drive(1'b0, 5 * BIT);
    drive(1'b1, 2 * BIT);
    chk("brk_pulse", 32'(brk_cnt), 32'd1);
    chk("brk_count", 32'(fifo_count), 32'd0);
    chk("brk_idle", 32'(rx_busy), 32'd0);
`else
    exp_q.push_back({1'b1, 1'b0, 8'h00});
    drive(1'b0, 9 * BIT + 30);
    drive(1'b1, 2 * BIT);
    chk("brk_count", 32'(fifo_count), 32'd1);
    chk("brk_idle", 32'(rx_busy), 32'd0);
    drain();
`endif

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
